// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the four-phase traffic-light controller.
package traffic_light_pkg;

  // Phase states in their fixed cyclic order.
  typedef enum logic [1:0] {
    S_NS_G = 2'd0,
    S_NS_Y = 2'd1,
    S_EW_G = 2'd2,
    S_EW_Y = 2'd3
  } state_e;

  // Default phase durations, in ticks.
  localparam int DEF_NS_GREEN_TICKS  = 5;
  localparam int DEF_NS_YELLOW_TICKS = 2;
  localparam int DEF_EW_GREEN_TICKS  = 5;
  localparam int DEF_EW_YELLOW_TICKS = 2;

  // Lamp vector layout: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
  function automatic logic [5:0] state_lamps(input state_e s);
    logic [5:0] v;
    case (s)
      S_NS_G:  v = 6'b100_001;
      S_NS_Y:  v = 6'b010_001;
      S_EW_G:  v = 6'b001_100;
      S_EW_Y:  v = 6'b001_010;
      default: v = 6'b001_001;  // all red is the safe fallback
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Tick strobe in, six lamp drives out.
interface traffic_light_ctrl_if;
  logic tick_1hz;
  logic ns_g;
  logic ns_y;
  logic ns_r;
  logic ew_g;
  logic ew_y;
  logic ew_r;

  // Upstream side: produces the tick, observes the lamps.
  modport master (
    output tick_1hz,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r
  );

  // Controller side: consumes the tick, drives the lamps.
  modport slave (
    input  tick_1hz,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r
  );
endinterface

// File: rtl/phase_timer.sv
// Counts ticks within the current phase; pulses done on the last tick.
module phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [CNT_W-1:0] dur_m1,
  input  logic             clear,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  assign done = tick && (r_cnt == dur_m1);

  // Tick counter: wraps to zero on the phase's final tick, holds without a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (done) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Four-phase Moore traffic-light controller; lamps come straight from registers.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int NS_GREEN_TICKS  = DEF_NS_GREEN_TICKS,
  parameter int NS_YELLOW_TICKS = DEF_NS_YELLOW_TICKS,
  parameter int EW_GREEN_TICKS  = DEF_EW_GREEN_TICKS,
  parameter int EW_YELLOW_TICKS = DEF_EW_YELLOW_TICKS
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_ctrl_if.slave tl_bus
);

  localparam int MAX_NS  = (NS_GREEN_TICKS > NS_YELLOW_TICKS) ? NS_GREEN_TICKS : NS_YELLOW_TICKS;
  localparam int MAX_EW  = (EW_GREEN_TICKS > EW_YELLOW_TICKS) ? EW_GREEN_TICKS : EW_YELLOW_TICKS;
  localparam int MAX_DUR = (MAX_NS > MAX_EW) ? MAX_NS : MAX_EW;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] NS_G_M1 = CNT_W'(NS_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] NS_Y_M1 = CNT_W'(NS_YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] EW_G_M1 = CNT_W'(EW_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] EW_Y_M1 = CNT_W'(EW_YELLOW_TICKS - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [5:0]       r_lamps;
  logic [CNT_W-1:0] w_dur_m1;
  logic             w_clear;
  logic             w_done;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk    (clk),
    .reset  (reset),
    .tick   (tl_bus.tick_1hz),
    .dur_m1 (w_dur_m1),
    .clear  (w_clear),
    .done   (w_done)
  );

  // Select the last-tick count for the current phase.
  always_comb begin
    w_dur_m1 = '0;
    case (r_state)
      S_NS_G:  w_dur_m1 = NS_G_M1;
      S_NS_Y:  w_dur_m1 = NS_Y_M1;
      S_EW_G:  w_dur_m1 = EW_G_M1;
      S_EW_Y:  w_dur_m1 = EW_Y_M1;
      default: w_dur_m1 = '0;
    endcase
  end

  // Next-state logic: advance on the phase's final tick, recover from bad encodings.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    case (r_state)
      S_NS_G: begin
        if (w_done) w_next_state = S_NS_Y;
        else        w_next_state = S_NS_G;
      end
      S_NS_Y: begin
        if (w_done) w_next_state = S_EW_G;
        else        w_next_state = S_NS_Y;
      end
      S_EW_G: begin
        if (w_done) w_next_state = S_EW_Y;
        else        w_next_state = S_EW_G;
      end
      S_EW_Y: begin
        if (w_done) w_next_state = S_NS_G;
        else        w_next_state = S_EW_Y;
      end
      default: begin
        w_next_state = S_NS_G;
        w_clear      = 1'b1;
      end
    endcase
  end

  // State and lamp registers; lamps are decoded from the state being loaded
  // so they change on the same edge as the state with no input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_NS_G;
      r_lamps <= state_lamps(S_NS_G);
    end else begin
      r_state <= w_next_state;
      r_lamps <= state_lamps(w_next_state);
    end
  end

  assign tl_bus.ns_g = r_lamps[5];
  assign tl_bus.ns_y = r_lamps[4];
  assign tl_bus.ns_r = r_lamps[3];
  assign tl_bus.ew_g = r_lamps[2];
  assign tl_bus.ew_y = r_lamps[1];
  assign tl_bus.ew_r = r_lamps[0];

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl against a tick-counting phase model.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic reset;

  traffic_light_ctrl_if tl_if ();

  traffic_light_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .tl_bus (tl_if.slave)
  );

  always #5 clk = ~clk;

  logic [5:0] lamps;
  assign lamps = {tl_if.ns_g, tl_if.ns_y, tl_if.ns_r, tl_if.ew_g, tl_if.ew_y, tl_if.ew_r};

  // Reference model: which phase we are in and how many ticks it has seen.
  int         dur_tbl  [4] = '{5, 2, 5, 2};
  logic [5:0] lamp_tbl [4] = '{6'b100001, 6'b010001, 6'b001100, 6'b001010};
  int         m_phase = 0;
  int         m_ticks = 0;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [5:0] pre_lamps;
  logic       last_t;
  logic       last_r;

  // Apply one cycle of inputs, advance the model, land 1 time unit after the edge.
  task automatic drive(input logic t, input logic r);
    tl_if.tick_1hz = t;
    reset          = r;
    pre_lamps      = lamps;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_ticks = 0;
    end else if (t) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == dur_tbl[m_phase]) begin
        m_phase = (m_phase + 1) % 4;
        m_ticks = 0;
      end
    end
    last_t = t;
    last_r = r;
    cyc    = cyc + 1;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    total++;
    if (lamps !== 6'b100001) begin
      bad++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, lamps, 6'b100001);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      total++;
      if (lamps !== 6'b100001) begin
        bad++; $display("FAIL reset_hold_ns_g tick=%0d got=%b exp=%b", k + 1, lamps, 6'b100001);
      end
    end
    drive(1'b1, 1'b0);
    total++;
    if (lamps !== 6'b010001) begin
      bad++; $display("FAIL reset_fifth_tick got=%b exp=%b", lamps, 6'b010001);
    end
  endtask

  // Run with a tick every n clocks and check lamps plus steady-state phase lengths.
  task automatic test_periodic(input int n, input int cycles);
    int         run_len;
    bit         seen_change;
    logic [5:0] prev_vec;
    int         exp_len;
    drive(1'b0, 1'b1);
    run_len     = 1;
    seen_change = 1'b0;
    prev_vec    = lamps;
    for (int i = 0; i < cycles; i++) begin
      drive((i % n) == (n - 1), 1'b0);
      total++;
      if (lamps !== lamp_tbl[m_phase]) begin
        bad++; $display("FAIL periodic_lamps n=%0d cyc=%0d got=%b exp=%b", n, cyc, lamps, lamp_tbl[m_phase]);
      end
      total++;
      if (!$onehot(lamps[5:3]) || !$onehot(lamps[2:0]) || (!lamps[3] && !lamps[0])) begin
        bad++; $display("FAIL periodic_invariant cyc=%0d got=%b exp=onehot_with_a_red", cyc, lamps);
      end
      if (lamps != prev_vec) begin
        if (seen_change) begin
          exp_len = (prev_vec == 6'b100001) ? 5 * n :
                    (prev_vec == 6'b010001) ? 2 * n :
                    (prev_vec == 6'b001100) ? 5 * n : 2 * n;
          total++;
          if (run_len != exp_len) begin
            bad++; $display("FAIL phase_length n=%0d phase=%b got=%0d exp=%0d", n, prev_vec, run_len, exp_len);
          end
        end
        seen_change = 1'b1;
        run_len     = 1;
        prev_vec    = lamps;
      end else begin
        run_len = run_len + 1;
      end
    end
  endtask

  task automatic test_reset_mid_phase();
    drive(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0);
    total++;
    if (lamps !== 6'b001100) begin
      bad++; $display("FAIL mid_reach_ew_g got=%b exp=%b", lamps, 6'b001100);
    end
    drive(1'b1, 1'b1);
    total++;
    if (lamps !== 6'b100001) begin
      bad++; $display("FAIL mid_reset_ns_g got=%b exp=%b", lamps, 6'b100001);
    end
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
    total++;
    if (lamps !== 6'b100001) begin
      bad++; $display("FAIL mid_four_ticks got=%b exp=%b", lamps, 6'b100001);
    end
    drive(1'b1, 1'b0);
    total++;
    if (lamps !== 6'b010001) begin
      bad++; $display("FAIL mid_fifth_tick got=%b exp=%b", lamps, 6'b010001);
    end
  endtask

  task automatic test_tick_in_reset();
    drive(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1);
      total++;
      if (lamps !== 6'b100001) begin
        bad++; $display("FAIL tick_in_reset cyc=%0d got=%b exp=%b", k, lamps, 6'b100001);
      end
    end
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
    total++;
    if (lamps !== 6'b100001) begin
      bad++; $display("FAIL tick_in_reset_cnt_cleared got=%b exp=%b", lamps, 6'b100001);
    end
    drive(1'b1, 1'b0);
    total++;
    if (lamps !== 6'b010001) begin
      bad++; $display("FAIL tick_in_reset_fifth got=%b exp=%b", lamps, 6'b010001);
    end
  endtask

  task automatic test_random();
    drive(1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
      total++;
      if (lamps !== lamp_tbl[m_phase]) begin
        bad++; $display("FAIL random_lamps cyc=%0d got=%b exp=%b", cyc, lamps, lamp_tbl[m_phase]);
      end
      total++;
      if (!$onehot(lamps[5:3]) || !$onehot(lamps[2:0]) || (!lamps[3] && !lamps[0])) begin
        bad++; $display("FAIL random_invariant cyc=%0d got=%b exp=onehot_with_a_red", cyc, lamps);
      end
      if (!last_t && !last_r) begin
        total++;
        if (lamps !== pre_lamps) begin
          bad++; $display("FAIL random_hold_no_tick cyc=%0d got=%b exp=%b", cyc, lamps, pre_lamps);
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    tl_if.tick_1hz = 1'b0;
    test_reset();
    test_periodic(10, 450);
    test_periodic(1, 40);
    test_reset_mid_phase();
    test_tick_in_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
